// File: rtl/oram_traffic_driver.sv
`default_nettype none
// ==== oram_traffic_driver : on-chip Path ORAM access generator and read-data checker  (rev 1.0) ====
module oram_traffic_driver #(
  parameter int ORAMU         = 32,
  parameter int ORAMB         = 512,
  parameter int FEDWidth      = 64,
  parameter int NumValidBlock = 8192,
  parameter int NumAccess     = 20000,
  parameter int nn            = 100,
  parameter int IssueGap      = 100
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  output logic [1:0]          Cmd,
  output logic [ORAMU-1:0]    PAddr,
  output logic                CmdValid,
  input  logic                CmdReady,
  output logic [FEDWidth-1:0] DataIn,
  output logic                DataInValid,
  input  logic                DataInReady,
  input  logic [FEDWidth-1:0] DataOut,
  input  logic                DataOutValid,
  output logic                DataOutReady,
  output logic                Done,
  output logic                Error,
  output logic [ORAMU-1:0]    ErrorAddr,
  output logic [31:0]         AccessCount
);

  localparam int CHUNKS = ORAMB / FEDWidth;
  localparam int IDXW   = (NumValidBlock > 1) ? $clog2(NumValidBlock) : 1;

  localparam logic [1:0] CMD_UPDATE = 2'b00;
  localparam logic [1:0] CMD_APPEND = 2'b01;
  localparam logic [1:0] CMD_READ   = 2'b10;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_GAP, S_CMD, S_WDATA, S_RDATA, S_NEXT, S_FIN, S_ERR
  } state_t;

  state_t             state;
  logic [IDXW-1:0]    init_idx;
  logic [31:0]        gap_cnt;
  logic [31:0]        off;
  logic               pass;
  logic [ORAMU-1:0]   base;
  logic [15:0]        chunk;
  logic               wr_g;
  logic [NumValidBlock-1:0] exist;
  logic [NumValidBlock-1:0] gen;

  logic [ORAMU-1:0]   next_addr;
  logic [IDXW-1:0]    next_idx;
  logic [IDXW-1:0]    cur_idx;
  logic [31:0]        count_inc;
  logic               last_chunk;
  logic               gap_done;
  logic               err_now;
  logic [ORAMU-1:0]   err_addr;

  function automatic logic [FEDWidth-1:0] chunk_word(input logic [ORAMU-1:0] a,
                                                     input logic [15:0] c,
                                                     input logic g);
    logic [FEDWidth-1:0] w;
    w = '0;
    w[ORAMU+31:0] = {a, c, 15'b0, g};
    return w;
  endfunction

  assign next_addr  = base + ORAMU'(off);
  assign next_idx   = next_addr[IDXW-1:0];
  assign cur_idx    = PAddr[IDXW-1:0];
  assign count_inc  = AccessCount + 32'd1;
  assign last_chunk = (chunk == 16'(CHUNKS - 1));
  assign gap_done   = (gap_cnt == 32'(IssueGap - 1));

  // All three error sources funnel into one ERR entry path.
  always_comb begin
    err_now  = 1'b0;
    err_addr = PAddr;
    case (state)
      S_GAP: begin
        err_addr = next_addr;
        err_now  = DataOutValid || (gap_done && (next_addr >= ORAMU'(NumValidBlock)));
      end
      S_CMD, S_WDATA, S_NEXT: err_now = DataOutValid;
      S_RDATA: err_now = DataOutValid && (DataOut != chunk_word(PAddr, chunk, gen[cur_idx]));
      default: err_now = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= S_INIT;
      init_idx     <= '0;
      gap_cnt      <= '0;
      off          <= '0;
      pass         <= 1'b0;
      base         <= '0;
      chunk        <= '0;
      wr_g         <= 1'b0;
      Cmd          <= '0;
      PAddr        <= '0;
      CmdValid     <= 1'b0;
      DataIn       <= '0;
      DataInValid  <= 1'b0;
      DataOutReady <= 1'b0;
      Done         <= 1'b0;
      Error        <= 1'b0;
      ErrorAddr    <= '0;
      AccessCount  <= '0;
    end else if (err_now) begin
      state        <= S_ERR;
      Error        <= 1'b1;
      ErrorAddr    <= err_addr;
      CmdValid     <= 1'b0;
      DataInValid  <= 1'b0;
      DataOutReady <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          exist[init_idx] <= 1'b0;
          gen[init_idx]   <= 1'b0;
          init_idx        <= init_idx + 1'b1;
          if (init_idx == IDXW'(NumValidBlock - 1)) begin
            state        <= S_IDLE;
            DataOutReady <= 1'b1;
          end
        end
        S_IDLE: begin
          if (Start) begin
            state   <= S_GAP;
            gap_cnt <= '0;
          end
        end
        S_GAP: begin
          if (gap_done) begin
            PAddr    <= next_addr;
            CmdValid <= 1'b1;
            chunk    <= '0;
            state    <= S_CMD;
            if (!exist[next_idx]) begin
              Cmd  <= CMD_APPEND;
              wr_g <= 1'b0;
            end else if (!next_addr[0]) begin
              Cmd  <= CMD_UPDATE;
              wr_g <= ~gen[next_idx];
            end else begin
              Cmd  <= CMD_READ;
            end
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        S_CMD: begin
          if (CmdReady) begin
            CmdValid <= 1'b0;
            if (Cmd == CMD_READ) begin
              state <= S_RDATA;
            end else begin
              DataIn      <= chunk_word(PAddr, 16'd0, wr_g);
              DataInValid <= 1'b1;
              state       <= S_WDATA;
            end
          end
        end
        S_WDATA: begin
          if (DataInReady) begin
            if (last_chunk) begin
              DataInValid    <= 1'b0;
              exist[cur_idx] <= 1'b1;
              gen[cur_idx]   <= wr_g;
              state          <= S_NEXT;
            end else begin
              chunk  <= chunk + 16'd1;
              DataIn <= chunk_word(PAddr, chunk + 16'd1, wr_g);
            end
          end
        end
        S_RDATA: begin
          // A mismatching beat never reaches here; err_now has already taken it.
          if (DataOutValid) begin
            if (last_chunk) state <= S_NEXT;
            else            chunk <= chunk + 16'd1;
          end
        end
        S_NEXT: begin
          AccessCount <= count_inc;
          if (count_inc == 32'(NumAccess)) begin
            Done  <= 1'b1;
            state <= S_FIN;
          end else begin
            if (off == 32'(nn - 1)) begin
              off  <= '0;
              pass <= ~pass;
              if (pass) base <= base + ORAMU'(2 * nn);
            end else begin
              off <= off + 32'd1;
            end
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oram_traffic_driver.sv
`default_nettype none
// ==== tb_oram_traffic_driver : scoreboard bench with an echoing ORAM model  (rev 1.0) ====
module tb_oram_traffic_driver;

  localparam int U    = 32;
  localparam int B    = 512;
  localparam int FW   = 64;
  localparam int NVB  = 1024;
  localparam int NACC = 400;
  localparam int NN   = 100;
  localparam int GAP  = 20;
  localparam int CH   = B / FW;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic          Reset, Start, CmdReady, DataInReady, DataOutValid;
  logic [FW-1:0] DataOut;
  logic [1:0]    Cmd;
  logic [U-1:0]  PAddr;
  logic          CmdValid;
  logic [FW-1:0] DataIn;
  logic          DataInValid, DataOutReady, Done, Error;
  logic [U-1:0]  ErrorAddr;
  logic [31:0]   AccessCount;

  logic          e_reset;
  logic          e_start   = 1'b1;
  logic          e_cmd_rdy = 1'b1;
  logic          e_din_rdy = 1'b1;
  logic          e_dout_v  = 1'b0;
  logic [FW-1:0] e_dout    = '0;
  logic [1:0]    e_cmd;
  logic [U-1:0]  e_paddr;
  logic          e_cmd_v;
  logic [FW-1:0] e_din;
  logic          e_din_v, e_dout_rdy, e_done, e_error;
  logic [U-1:0]  e_err_addr;
  logic [31:0]   e_count;
  int            e_cmds = 0;

  oram_traffic_driver #(
    .ORAMU(U), .ORAMB(B), .FEDWidth(FW), .NumValidBlock(NVB),
    .NumAccess(NACC), .nn(NN), .IssueGap(GAP)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .Cmd(Cmd), .PAddr(PAddr), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
    .DataOut(DataOut), .DataOutValid(DataOutValid), .DataOutReady(DataOutReady),
    .Done(Done), .Error(Error), .ErrorAddr(ErrorAddr), .AccessCount(AccessCount)
  );

  // Small instance whose address walk (nn=1, even blocks only) overruns NumValidBlock=16.
  oram_traffic_driver #(
    .ORAMU(U), .ORAMB(B), .FEDWidth(FW), .NumValidBlock(16),
    .NumAccess(1000), .nn(1), .IssueGap(2)
  ) dut_e (
    .Clock(Clock), .Reset(e_reset), .Start(e_start),
    .Cmd(e_cmd), .PAddr(e_paddr), .CmdValid(e_cmd_v), .CmdReady(e_cmd_rdy),
    .DataIn(e_din), .DataInValid(e_din_v), .DataInReady(e_din_rdy),
    .DataOut(e_dout), .DataOutValid(e_dout_v), .DataOutReady(e_dout_rdy),
    .Done(e_done), .Error(e_error), .ErrorAddr(e_err_addr), .AccessCount(e_count)
  );

  always @(posedge Clock) if (e_cmd_v && e_cmd_rdy) e_cmds <= e_cmds + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] exp_chunk(input int a, input int c, input bit g);
    return {32'(a), 16'(c), 15'b0, g};
  endfunction

  // Reference model and ORAM echo storage
  int            k;
  bit            ref_exist [NVB];
  bit            ref_gen   [NVB];
  logic [FW-1:0] wq [$];
  logic [FW-1:0] mem [int];
  int            w_addr, w_c, rd_left, rd_addr, rd_c;
  int            hold_left     = 50;
  int            corrupt_addr  = -1;
  int            corrupt_chunk = 0;
  logic [FW-1:0] corrupt_mask  = '0;
  bit            corrupt_sent;
  bit            pend_cmd, pend_din;
  logic [63:0]   pend_cmd_val;
  logic [FW-1:0] pend_din_val;

  task automatic model_clear();
    k = 0; w_addr = 0; w_c = 0; rd_left = 0; rd_addr = 0; rd_c = 0;
    foreach (ref_exist[i]) begin ref_exist[i] = 1'b0; ref_gen[i] = 1'b0; end
    wq.delete();
    mem.delete();
    pend_cmd = 1'b0; pend_din = 1'b0; corrupt_sent = 1'b0;
  endtask

  task automatic on_cmd();
    int a; bit g; logic [1:0] op;
    g = 1'b0;
    check("burst_len", 64'(wq.size()), 64'd0);
    a = (k / (2 * NN)) * (2 * NN) + k % NN;
    if (!ref_exist[a])  op = 2'b01;
    else if (a % 2 == 0) begin op = 2'b00; g = ~ref_gen[a]; end
    else                op = 2'b10;
    check("cmd_op", 64'(Cmd), 64'(op));
    check("cmd_addr", 64'(PAddr), 64'(a));
    if (op == 2'b10) begin
      rd_left = CH; rd_addr = a; rd_c = 0;
    end else begin
      for (int c = 0; c < CH; c++) wq.push_back(exp_chunk(a, c, g));
      ref_exist[a] = 1'b1; ref_gen[a] = g; w_addr = a; w_c = 0;
    end
    k++;
  endtask

  task automatic on_din();
    logic [FW-1:0] e;
    e = (wq.size() > 0) ? wq.pop_front() : '1;
    check("din_data", DataIn, e);
    mem[w_addr * CH + w_c] = DataIn;
    w_c++;
  endtask

  // ORAM model: decides readies and read beats half a cycle ahead of each rising edge.
  initial begin
    CmdReady = 1'b0; DataInReady = 1'b0; DataOutValid = 1'b0; DataOut = '0;
    model_clear();
    forever begin
      @(negedge Clock); #1;
      if (corrupt_sent) begin
        corrupt_sent = 1'b0;
        check("err_flag", 64'(Error), 64'd1);
        check("err_addr_now", 64'(ErrorAddr), 64'(corrupt_addr));
      end
      if (Reset) begin
        model_clear();
        CmdReady = 1'b0; DataInReady = 1'b0; DataOutValid = 1'b0;
        continue;
      end
      if (pend_cmd) check("cmd_hold", {29'b0, CmdValid, Cmd, PAddr}, pend_cmd_val);
      if (pend_din) begin
        check("din_hold_v", 64'(DataInValid), 64'd1);
        check("din_hold_d", DataIn, pend_din_val);
      end
      DataOutValid = 1'b0;
      if (rd_left > 0 && $urandom_range(0, 3) != 0) begin
        DataOut = mem.exists(rd_addr * CH + rd_c) ? mem[rd_addr * CH + rd_c] : '0;
        if (rd_addr == corrupt_addr && rd_c == corrupt_chunk) begin
          DataOut = DataOut ^ corrupt_mask;
          check("pre_err", 64'(Error), 64'd0);
          corrupt_sent = 1'b1;
        end
        DataOutValid = 1'b1;
        rd_c++; rd_left--;
      end
      if (CmdValid && hold_left > 0) begin CmdReady = 1'b0; hold_left--; end
      else CmdReady = 1'b1;
      DataInReady = 1'($urandom_range(0, 1));
      pend_cmd     = CmdValid && !CmdReady;
      pend_cmd_val = {29'b0, CmdValid, Cmd, PAddr};
      pend_din     = DataInValid && !DataInReady;
      pend_din_val = DataIn;
      if (CmdValid && CmdReady)       on_cmd();
      if (DataInValid && DataInReady) on_din();
    end
  end

  task automatic wait_end(input int bound);
    int n;
    n = 0;
    while (!Done && !Error && n < bound) begin @(negedge Clock); n++; end
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!DataOutReady && n < NVB + 20) begin @(negedge Clock); n++; end
    check(tag, 64'(n), 64'(NVB));
  endtask

  initial begin
    int n;
    Reset = 1'b1; e_reset = 1'b1; Start = 1'b0;
    repeat (5) @(negedge Clock);
    check("rst_cmdv",  64'(CmdValid), 64'd0);
    check("rst_dinv",  64'(DataInValid), 64'd0);
    check("rst_doutr", 64'(DataOutReady), 64'd0);
    check("rst_done",  64'(Done), 64'd0);
    check("rst_err",   64'(Error), 64'd0);
    check("rst_eaddr", 64'(ErrorAddr), 64'd0);
    check("rst_cnt",   64'(AccessCount), 64'd0);
    check("rst_cmd",   64'(Cmd), 64'd0);
    check("rst_paddr", 64'(PAddr), 64'd0);
    check("rst_din",   DataIn, 64'd0);
    Reset = 1'b0; e_reset = 1'b0;
    wait_init("init_len");

    // Count includes the IDLE->GAP edge itself, then IssueGap GAP cycles.
    Start = 1'b1;
    n = 0;
    while (!CmdValid && n < GAP + 20) begin @(negedge Clock); n++; end
    check("gap_len", 64'(n), 64'(GAP + 1));
    check("first_cmd", 64'(Cmd), 64'd1);
    check("first_addr", 64'(PAddr), 64'd0);

    wait_end(40000);
    @(negedge Clock);
    check("done", 64'(Done), 64'd1);
    check("error", 64'(Error), 64'd0);
    check("count", 64'(AccessCount), 64'(NACC));
    check("issued", 64'(k), 64'(NACC));
    check("fin_cmdv", 64'(CmdValid), 64'd0);
    check("fin_dinv", 64'(DataInValid), 64'd0);

    // Second run: reset in the middle of a write burst, then corrupt a read.
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    wait_init("init_len2");
    n = 0;
    while (!(AccessCount == 32'd2 && DataInValid && DataIn[31:16] == 16'd4) && n < 3000) begin
      @(negedge Clock); n++;
    end
    check("reach_chunk4", 64'(DataIn[31:16]), 64'd4);
    Reset = 1'b1;
    @(negedge Clock);
    check("mid_cmdv", 64'(CmdValid), 64'd0);
    check("mid_dinv", 64'(DataInValid), 64'd0);
    check("mid_cnt", 64'(AccessCount), 64'd0);
    check("mid_doutr", 64'(DataOutReady), 64'd0);
    corrupt_addr = 3; corrupt_chunk = 5; corrupt_mask = 64'h0000_0000_0010_0000;
    Reset = 1'b0;
    wait_init("init_len3");
    wait_end(20000);
    @(negedge Clock);
    check("c_err", 64'(Error), 64'd1);
    check("c_eaddr", 64'(ErrorAddr), 64'd3);
    check("c_cnt", 64'(AccessCount), 64'd103);
    check("c_done", 64'(Done), 64'd0);
    check("c_cmdv", 64'(CmdValid), 64'd0);

    // Third run: stale generation bit echoed for block 5.
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    corrupt_addr = 5; corrupt_chunk = 0; corrupt_mask = 64'd1;
    Reset = 1'b0;
    wait_init("init_len4");
    wait_end(20000);
    @(negedge Clock);
    check("s_err", 64'(Error), 64'd1);
    check("s_eaddr", 64'(ErrorAddr), 64'd5);
    check("s_cnt", 64'(AccessCount), 64'd105);

    check("e_err", 64'(e_error), 64'd1);
    check("e_eaddr", 64'(e_err_addr), 64'd16);
    check("e_cnt", 64'(e_count), 64'd16);
    check("e_cmds", 64'(e_cmds), 64'd16);
    check("e_done", 64'(e_done), 64'd0);
    check("e_cmdv", 64'(e_cmd_v), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
